// File: rtl/if_debug_controller.sv
// Debug-link sequencer for the instruction-fetch stage: program load, run, single-step, halt.
// Define IF_DEBUG_CYCLE_COUNT_EN to add the saturating o_cycle_count output.
module if_debug_controller #(
    parameter int NB_DATA        = 8,
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_ADDR        = 8,
`ifdef IF_DEBUG_CYCLE_COUNT_EN
    parameter int NB_CYCLE       = 16,
`endif
    parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [NB_DATA-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    input  logic [NB_INSTRUCTION-1:0] i_fetched_instruction,
    output logic                      o_imem_write_enable,
    output logic [NB_ADDR-1:0]        o_imem_write_addr,
    output logic [NB_INSTRUCTION-1:0] o_imem_write_data,
    output logic                      o_pc_enable,
    output logic                      o_pc_reset,
    output logic                      o_read_enable,
    output logic                      o_busy,
    output logic                      o_halted
`ifdef IF_DEBUG_CYCLE_COUNT_EN
    ,
    output logic [NB_CYCLE-1:0]       o_cycle_count
`endif
);

    localparam int NB_BYTES = NB_INSTRUCTION / NB_DATA;
    localparam int NB_IDX   = $clog2(NB_BYTES);
    localparam int NB_SHIFT = NB_INSTRUCTION - NB_DATA;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_BYTES - 1);

    localparam logic [NB_DATA-1:0] CMD_LOAD  = NB_DATA'(8'h4C);
    localparam logic [NB_DATA-1:0] CMD_RUN   = NB_DATA'(8'h43);
    localparam logic [NB_DATA-1:0] CMD_STEP  = NB_DATA'(8'h53);
    localparam logic [NB_DATA-1:0] CMD_NEXT  = NB_DATA'(8'h4E);
    localparam logic [NB_DATA-1:0] CMD_RESET = NB_DATA'(8'h52);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COUNT,
        LOAD_BYTE,
        RUN,
        STEP,
        HALT
    } state_t;

    state_t                      state, state_next;
    logic [NB_DATA-1:0]          words_left, words_left_next;
    logic [NB_ADDR-1:0]          addr, addr_next;
    logic [NB_IDX-1:0]           byte_idx, byte_idx_next;
    logic [NB_SHIFT-1:0]         shift, shift_next;
    logic                        fetch_valid;
    logic                        halt_match;

    logic                        imem_we_next;
    logic [NB_ADDR-1:0]          imem_addr_next;
    logic [NB_INSTRUCTION-1:0]   imem_data_next;
    logic                        pc_enable_next;
    logic                        pc_reset_next;
    logic                        read_enable_next;

    // The word on i_fetched_instruction is only meaningful one cycle after a read was enabled.
    assign halt_match = fetch_valid && (i_fetched_instruction == HALT_INSTRUCTION);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= IDLE;
            words_left          <= '0;
            addr                <= '0;
            byte_idx            <= '0;
            shift               <= '0;
            fetch_valid         <= 1'b0;
            o_imem_write_enable <= 1'b0;
            o_imem_write_addr   <= '0;
            o_imem_write_data   <= '0;
            o_pc_enable         <= 1'b0;
            o_pc_reset          <= 1'b1;
            o_read_enable       <= 1'b0;
            o_busy              <= 1'b0;
            o_halted            <= 1'b0;
        end else begin
            state               <= state_next;
            words_left          <= words_left_next;
            addr                <= addr_next;
            byte_idx            <= byte_idx_next;
            shift               <= shift_next;
            fetch_valid         <= o_read_enable;
            o_imem_write_enable <= imem_we_next;
            o_imem_write_addr   <= imem_addr_next;
            o_imem_write_data   <= imem_data_next;
            o_pc_enable         <= pc_enable_next;
            o_pc_reset          <= pc_reset_next;
            o_read_enable       <= read_enable_next;
            o_busy              <= (state_next != IDLE) && (state_next != HALT);
            o_halted            <= (state_next == HALT);
        end
    end

    always_comb begin
        state_next       = state;
        words_left_next  = words_left;
        addr_next        = addr;
        byte_idx_next    = byte_idx;
        shift_next       = shift;
        imem_we_next     = 1'b0;
        imem_addr_next   = o_imem_write_addr;
        imem_data_next   = o_imem_write_data;
        pc_enable_next   = 1'b0;
        pc_reset_next    = 1'b0;
        read_enable_next = 1'b0;

        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD:  state_next = LOAD_COUNT;
                        CMD_RUN: begin
                            state_next       = RUN;
                            pc_enable_next   = 1'b1;
                            read_enable_next = 1'b1;
                        end
                        CMD_STEP:  state_next = STEP;
                        CMD_RESET: pc_reset_next = 1'b1;
                        default: ;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next      = LOAD_BYTE;
                        words_left_next = i_rx_data;
                        addr_next       = '0;
                        byte_idx_next   = '0;
                    end
                end
            end
            LOAD_BYTE: begin
                // Every byte here is payload, including ones that look like commands.
                if (i_rx_valid) begin
                    if (byte_idx == LAST_IDX) begin
                        imem_we_next    = 1'b1;
                        imem_addr_next  = addr;
                        imem_data_next  = {shift, i_rx_data};
                        addr_next       = addr + NB_ADDR'(1);
                        byte_idx_next   = '0;
                        words_left_next = words_left - NB_DATA'(1);
                        if (words_left == NB_DATA'(1)) begin
                            state_next    = IDLE;
                            pc_reset_next = 1'b1;
                        end
                    end else begin
                        shift_next    = {shift[NB_SHIFT-NB_DATA-1:0], i_rx_data};
                        byte_idx_next = byte_idx + NB_IDX'(1);
                    end
                end
            end
            RUN: begin
                if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
                    state_next    = IDLE;
                    pc_reset_next = 1'b1;
                end else if (halt_match) begin
                    state_next = HALT;
                end else begin
                    pc_enable_next   = 1'b1;
                    read_enable_next = 1'b1;
                end
            end
            STEP: begin
                if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
                    state_next    = IDLE;
                    pc_reset_next = 1'b1;
                end else if (halt_match) begin
                    state_next = HALT;
                end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
                    state_next       = RUN;
                    pc_enable_next   = 1'b1;
                    read_enable_next = 1'b1;
                end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
                    pc_enable_next   = 1'b1;
                    read_enable_next = 1'b1;
                end
            end
            HALT: begin
                if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
                    state_next    = IDLE;
                    pc_reset_next = 1'b1;
                end else if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
                    state_next = LOAD_COUNT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IF_DEBUG_CYCLE_COUNT_EN
    // Counts enabled fetch cycles; cleared together with each PC reset pulse.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cycle_count <= '0;
        end else if (pc_reset_next) begin
            o_cycle_count <= '0;
        end else if (o_pc_enable && (o_cycle_count != '1)) begin
            o_cycle_count <= o_cycle_count + NB_CYCLE'(1);
        end
    end
`endif

endmodule

// File: doc/if_debug_controller.md
Name: if_debug_controller

Overview:
- Sequences the instruction-fetch stage from a byte-oriented debug link (UART RX byte stream).
- Loads programs into instruction memory word by word.
- Owns the IF-stage controls (PC enable, PC reset, instruction-memory read enable) in continuous-run and single-step modes.
- Stops fetch when the HALT instruction is fetched.

Parameters:
NB_DATA, 8, width of received debug bytes
NB_INSTRUCTION, 32, instruction word width (4 bytes)
NB_ADDR, 8, instruction-memory word-address width
NB_CYCLE, 16, width of executed-cycle counter
HALT_INSTRUCTION, 32'hFFFFFFFF, encoding that halts fetch

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_rx_data  in  NB_DATA  received byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
i_fetched_instruction  in  NB_INSTRUCTION  instruction word output by the IF stage
o_imem_write_enable  out  1  one-cycle instruction-memory write strobe
o_imem_write_addr  out  NB_ADDR  instruction-memory write word address
o_imem_write_data  out  NB_INSTRUCTION  instruction-memory write data
o_pc_enable  out  1  to IF-stage PC enable
o_pc_reset  out  1  to IF-stage PC reset, active-high
o_read_enable  out  1  to IF-stage instruction-memory read enable
o_busy  out  1  high in any state except IDLE/HALT
o_halted  out  1  high in HALT

Behaviour:
- Clock/reset: one clock (i_clock); reset asynchronous active-low (i_reset_n).
- All outputs registered.
- Reset values:
  - state IDLE
  - o_pc_reset=1; all other outputs 0; address and byte counters 0.
  - First rising edge after release drives o_pc_reset=0.
- Commands: bytes taken only on i_rx_valid.
  - 'L'=0x4C load
  - 'C'=0x43 continuous run
  - 'S'=0x53 step mode
  - 'N'=0x4E next step
  - 'R'=0x52 reset/abort
  - Unlisted bytes ignored in every state.
- States: IDLE, LOAD_COUNT, LOAD_BYTE, RUN, STEP, HALT.
- IDLE:
  - 'L' -> LOAD_COUNT
  - 'C' -> RUN
  - 'S' -> STEP
  - 'R' -> one-cycle o_pc_reset pulse, stay IDLE
- LOAD_COUNT:
  - Next byte = word count W.
  - W=0 -> IDLE, no writes.
  - Else latch W, address=0, byte index=0 -> LOAD_BYTE.
- LOAD_BYTE:
  - Bytes assembled MSB first into a shift register.
  - On 4th byte: o_imem_write_enable=1 for one cycle, o_imem_write_data = assembled word, o_imem_write_addr = current address; address then increments.
  - After W-th word -> IDLE with one-cycle o_pc_reset pulse.
  - Address wraps modulo 2^NB_ADDR.
  - 'R' byte inside load is data, not a command.
  - o_pc_enable=0 and o_read_enable=0 throughout.
- RUN:
  - o_pc_enable=1 and o_read_enable=1 every cycle.
  - Memory read is synchronous. i_fetched_instruction is compared each cycle whose previous cycle had o_read_enable=1.
  - Match with HALT_INSTRUCTION -> next edge: o_pc_enable=0, o_read_enable=0, state HALT. PC overshoot of one fetch is accepted.
  - 'R' -> enables low, o_pc_reset pulse, IDLE. 'R' wins over a same-cycle HALT match.
- STEP:
  - Enables idle low.
  - Each 'N' -> o_pc_enable=1 and o_read_enable=1 for exactly one cycle.
  - HALT compare in the cycle following the pulse; match -> HALT.
  - 'N' arriving during the compare cycle is accepted normally.
  - 'C' -> RUN.
  - 'R' -> o_pc_reset pulse, IDLE.
- HALT:
  - Enables low, o_halted=1.
  - 'R' -> o_pc_reset pulse, IDLE.
  - 'L' -> LOAD_COUNT.
  - Others ignored.
- o_pc_reset is never high in the same cycle as o_pc_enable.
- Reset mid-operation: immediate return to reset values; a partial word is discarded.

Optional Feature:
- Macro: IF_DEBUG_CYCLE_COUNT_EN.
- When defined: adds output port o_cycle_count (NB_CYCLE, out).
  - Increments each cycle o_pc_enable=1; saturates at all-ones.
  - Cleared on o_pc_reset pulse and on reset.
  - Holds its value in HALT.
- When undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset release -> o_pc_reset=1 during reset, 0 one cycle after; all other outputs 0, o_busy=0.
- Rx 0x4C, 0x02, then bytes 12 34 56 78 AA BB CC DD -> writes 0x12345678@0 and 0xAABBCCDD@1, each a one-cycle strobe; then o_pc_reset pulse, IDLE.
- Load 3 words (NOP, NOP, 0xFFFFFFFF), rx 0x43 -> enables high; halt fetched -> enables low next edge, o_halted=1; o_cycle_count=4 with macro.
- Rx 0x53 then 0x4E twice -> exactly two one-cycle o_pc_enable pulses; 0x52 -> o_pc_reset pulse, IDLE.
- RUN, rx 0x52 in the same cycle as a HALT match -> IDLE with reset pulse, not HALT.
- Load with W=0 -> no write strobe, IDLE; assert i_reset_n low after 2 of 4 bytes -> no write, state IDLE.
